// File: rtl/temporal_sequencer.sv
// Temporal n-gram sequencer: clears the encoder at each window boundary,
// drops the warm-up partial n-grams and forwards WINDOW full n-grams,
// tagging the last one of each window.

`ifndef HV_DIMENSION
`define HV_DIMENSION 1024
`endif
`ifndef NGRAM_SIZE
`define NGRAM_SIZE 3
`endif

module temporal_sequencer #(
  parameter int unsigned HV_DIM = `HV_DIMENSION,
  parameter int unsigned NGRAM  = `NGRAM_SIZE,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hvin_valid,
  output logic              hvin_ready,
  input  logic [HV_DIM-1:0] hvin,
  output logic              enc_clear,
  output logic              enc_in_valid,
  input  logic              enc_in_ready,
  output logic [HV_DIM-1:0] enc_in,
  input  logic              enc_out_valid,
  output logic              enc_out_ready,
  input  logic [HV_DIM-1:0] enc_out,
  output logic              hvout_valid,
  input  logic              hvout_ready,
  output logic [HV_DIM-1:0] hvout,
  output logic              hvout_last,
  output logic              busy,
  output logic [WCNT_W-1:0] win_count
);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  // Warm-up counter only needs to reach NGRAM-1; window counter WINDOW-1.
  localparam int unsigned FILL_W    = (NGRAM > 2) ? $clog2(NGRAM) : 1;
  localparam int unsigned WIN_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned FILL_LAST = (NGRAM > 1) ? NGRAM - 2 : 0;
  localparam int unsigned WIN_LAST  = WINDOW - 1;

  // A 1-gram encoder has no partial outputs, so the fill phase is skipped.
  localparam logic [1:0] AFTER_CLEAR = (NGRAM == 1) ? RUN : FILL;

  logic [1:0]        state;
  logic [1:0]        state_d;
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_cnt_d;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W-1:0]  win_cnt_d;
  logic [WCNT_W-1:0] win_count_d;

  // Data paths are plain wires; only the handshakes are steered.
  assign enc_in = hvin;
  assign hvout  = enc_out;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      fill_cnt  <= '0;
      win_cnt   <= '0;
      win_count <= '0;
    end else begin
      state     <= state_d;
      fill_cnt  <= fill_cnt_d;
      win_cnt   <= win_cnt_d;
      win_count <= win_count_d;
    end
  end

  // Next-state logic and handshake steering.
  always_comb begin
    state_d       = state;
    fill_cnt_d    = fill_cnt;
    win_cnt_d     = win_cnt;
    win_count_d   = win_count;
    enc_clear     = 1'b0;
    hvin_ready    = 1'b0;
    enc_in_valid  = 1'b0;
    enc_out_ready = 1'b0;
    hvout_valid   = 1'b0;
    hvout_last    = 1'b0;
    busy          = 1'b0;

    case (state)
      CLEAR: begin
        enc_clear  = 1'b1;
        fill_cnt_d = '0;
        win_cnt_d  = '0;
        if (!flush) begin
          state_d = AFTER_CLEAR;
        end
      end

      FILL: begin
        busy          = 1'b1;
        enc_in_valid  = hvin_valid;
        hvin_ready    = enc_in_ready;
        enc_out_ready = 1'b1;
        // Partial n-grams are consumed and dropped.
        if (enc_out_valid) begin
          fill_cnt_d = fill_cnt + FILL_W'(1);
          if (fill_cnt == FILL_W'(FILL_LAST)) begin
            state_d = RUN;
          end
        end
        if (flush) begin
          state_d = CLEAR;
        end
      end

      RUN: begin
        busy          = 1'b1;
        enc_in_valid  = hvin_valid;
        hvin_ready    = enc_in_ready;
        hvout_valid   = enc_out_valid;
        enc_out_ready = hvout_ready;
        hvout_last    = enc_out_valid && (win_cnt == WIN_W'(WIN_LAST));
        // A fire in the flush cycle still counts, including the last one.
        if (enc_out_valid && hvout_ready) begin
          win_cnt_d = win_cnt + WIN_W'(1);
          if (win_cnt == WIN_W'(WIN_LAST)) begin
            win_count_d = win_count + WCNT_W'(1);
            state_d     = CLEAR;
          end
        end
        if (flush) begin
          state_d = CLEAR;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

// File: doc/temporal_sequencer.md
Name: temporal_sequencer

Overview:
- Controller that sequences the temporal n-gram encoder between the spatial encoder and the associative-memory stage.
- Clears the encoder at every window boundary and steers the upstream hypervector stream into it.
- Discards the first NGRAM-1 warm-up outputs of each window, which are partial n-grams, and forwards exactly WINDOW full n-grams downstream, tagging the final one as last.
- Supports a synchronous flush that aborts the current window.

Parameters:
HV_DIM, `HV_DIMENSION, hypervector width in bits.
NGRAM, `NGRAM_SIZE, n-gram depth of the attached encoder; must be at least 1.
WINDOW, 16, full n-grams forwarded per window; must be at least 1.
WCNT_W, 16, width of the completed-window counter.

Ports:
clk  in  1  clock.
rst  in  1  reset: asynchronous, active-high.
flush  in  1  synchronous request to abort the current window.
hvin_valid  in  1  upstream hypervector valid.
hvin_ready  out  1  upstream ready.
hvin  in  HV_DIM  upstream spatial hypervector.
enc_clear  out  1  synchronous clear to the encoder; the encoder reset is driven by enc_clear.
enc_in_valid  out  1  encoder input valid.
enc_in_ready  in  1  encoder input ready.
enc_in  out  HV_DIM  encoder input; equals hvin.
enc_out_valid  in  1  encoder output valid.
enc_out_ready  out  1  encoder output ready.
enc_out  in  HV_DIM  encoder n-gram output.
hvout_valid  out  1  downstream valid.
hvout_ready  in  1  downstream ready.
hvout  out  HV_DIM  downstream n-gram; equals enc_out.
hvout_last  out  1  marks the final n-gram of a window.
busy  out  1  high in the FILL and RUN states.
win_count  out  WCNT_W  count of completed windows; wraps at 2^WCNT_W.

Behaviour:
- States are CLEAR, FILL and RUN. Async reset forces state=CLEAR, fill_cnt=0, win_cnt=0, win_count=0.
- Outputs in reset: enc_clear=1; hvin_ready, enc_in_valid, enc_out_ready, hvout_valid, hvout_last and busy all 0.
- CLEAR:
  - Drive enc_clear=1; hvin_ready=0, enc_in_valid=0, enc_out_ready=0, hvout_valid=0.
  - Stay exactly 1 cycle, then go to FILL, or to RUN when NGRAM==1.
  - Reset fill_cnt and win_cnt to 0.
- FILL and RUN input path: enc_in_valid=hvin_valid and hvin_ready=enc_in_ready. This is purely combinational, so there is no added latency.
- FILL output path:
  - enc_out_ready=1 and hvout_valid=0.
  - Each enc_out fire is dropped and increments fill_cnt.
  - On the fire that brings fill_cnt to NGRAM-1, go to RUN.
- RUN output path:
  - hvout_valid=enc_out_valid, enc_out_ready=hvout_ready, hvout=enc_out.
  - hvout_last = (win_cnt==WINDOW-1) && hvout_valid.
  - Each hvout fire increments win_cnt.
  - The fire with hvout_last set increments win_count and moves to CLEAR.
- Count accounting: counts are of encoder outputs, not inputs. Each window therefore consumes NGRAM-1+WINDOW upstream hypervectors.
- flush:
  - In FILL or RUN, the next state is CLEAR; any pending encoder output is discarded by the clear.
  - A downstream fire in the flush cycle still completes. If that fire carries hvout_last, win_count increments.
  - A flush in CLEAR keeps the block in CLEAR for one additional cycle.
- Reset mid-window: all state returns to reset values immediately, without waiting for a clock edge. Nothing is forwarded until a new window completes its fill.
- hvout and hvout_last must be stable while hvout_valid=1 and hvout_ready=0. This holds because the encoder holds its output until it is consumed.

Test Plan:
1. Nominal window: NGRAM=3, WINDOW=4, 6 inputs with continuous ready -> enc_clear for 1 cycle; first 2 outputs dropped; 4 hvout fires with hvout_last on the 4th; win_count=1; then enc_clear pulses again.
2. Back-to-back windows: 18 inputs -> 3 windows, 12 hvout fires, win_count=3; each CLEAR gap has hvin_ready=0 for exactly 1 cycle.
3. Backpressure: hvout_ready=0 for 5 cycles mid-RUN -> hvout stable, hvin_ready=0 (encoder busy), no loss, 4 fires total.
4. Flush mid-RUN after 2 fires -> CLEAR, win_count unchanged. The next window requires 6 inputs and the first 2 outputs are dropped again.
5. Flush coincident with the last fire -> win_count increments, single CLEAR, normal next window.
6. Async rst asserted mid-FILL, between clock edges -> enc_clear=1, hvout_valid=0 and win_count=0 before the next edge; a full window follows deassertion.
